// File: rtl/lsu_controller.sv
// lsu_controller: multi-cycle load/store sequencer between decode and the data bus.
// Captures one load/store per request, drives a valid/ready bus request with byte
// enables and lane-replicated store data, extends load data, and stalls the pipe.
// Ports: clk, rst_n (async low); red_enable/write_enable/memory_type/addr/store_data
// from the pipeline; bus_req_* / bus_we / bus_addr / bus_be / bus_wdata request side;
// bus_rsp_valid / bus_rdata response side; stall, load_valid, load_data to the pipe.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses skip the bus and pulse
// misalign_fault; otherwise they are silently aligned.
module lsu_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              red_enable,
  input  logic              write_enable,
  input  logic [2:0]        memory_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic              misalign_fault,
`endif
  output logic              stall,
  output logic              load_valid,
  output logic [DATA_W-1:0] load_data
);

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_WAIT, S_DONE
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  function automatic logic [1:0] size_of(input logic [2:0] t);
    logic [1:0] s;
    s = SZ_W;
    unique case (1'b1)
      (t == 3'b000) || (t == 3'b011): s = SZ_B;
      (t == 3'b001) || (t == 3'b100): s = SZ_H;
      default:                        s = SZ_W;
    endcase
    return s;
  endfunction

  state_t state, state_nx;

  logic              store_q;
  logic [2:0]        type_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] ld_q;
  logic              req;
  logic              trap_in;
  logic              fault_q;
  logic [1:0]        q_sz;
  logic [1:0]        off;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] ext;

  assign req  = write_enable | red_enable;
  assign q_sz = size_of(type_q);

`ifdef LSU_MISALIGN_TRAP_EN
  logic [1:0] in_sz;
  assign in_sz   = size_of(memory_type);
  assign trap_in = ((in_sz == SZ_H) && addr[0]) ||
                   ((in_sz == SZ_W) && (addr[1:0] != 2'b00));
`else
  assign trap_in = 1'b0;
`endif

  // Misaligned halves/words are forced onto their natural boundary.
  always_comb begin
    off = 2'b00;
    unique case (q_sz)
      SZ_B:    off = addr_q[1:0];
      SZ_H:    off = {addr_q[1], 1'b0};
      default: off = 2'b00;
    endcase
  end

  assign sh = bus_rdata >> {off, 3'b000};

  always_comb begin
    ext = sh;
    unique case (1'b1)
      (type_q == 3'b000): ext = {{24{sh[7]}}, sh[7:0]};
      (type_q == 3'b001): ext = {{16{sh[15]}}, sh[15:0]};
      (type_q == 3'b011): ext = {24'd0, sh[7:0]};
      (type_q == 3'b100): ext = {16'd0, sh[15:0]};
      default:            ext = sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (req) state_nx = trap_in ? S_DONE : S_REQ;
      S_REQ:  if (bus_req_ready) state_nx = store_q ? S_DONE : S_WAIT;
      S_WAIT: if (bus_rsp_valid) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q <= 1'b0;
      type_q  <= 3'd0;
      addr_q  <= '0;
      data_q  <= '0;
      ld_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      if (state == S_IDLE && req) begin
        store_q <= write_enable;
        type_q  <= memory_type;
        addr_q  <= addr;
        data_q  <= store_data;
        fault_q <= trap_in;
      end
      if (state == S_WAIT && bus_rsp_valid) begin
        ld_q <= ext;
      end
    end
  end

  assign load_data = ld_q;

  always_comb begin
    bus_req_valid = 1'b0;
    bus_we        = 1'b0;
    bus_addr      = '0;
    bus_be        = 4'b0000;
    bus_wdata     = '0;
    stall         = 1'b0;
    load_valid    = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_fault = 1'b0;
`endif
    unique case (state)
      S_IDLE: stall = req;
      S_REQ: begin
        bus_req_valid = 1'b1;
        stall         = 1'b1;
        bus_we        = store_q;
        bus_addr      = {addr_q[ADDR_W-1:2], 2'b00};
        unique case (q_sz)
          SZ_B: begin
            bus_be    = 4'b0001 << off;
            bus_wdata = {4{data_q[7:0]}};
          end
          SZ_H: begin
            bus_be    = 4'b0011 << off;
            bus_wdata = {2{data_q[15:0]}};
          end
          default: begin
            bus_be    = 4'b1111;
            bus_wdata = data_q;
          end
        endcase
      end
      S_WAIT: stall = 1'b1;
      S_DONE: begin
        load_valid = !store_q && !fault_q;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_fault = fault_q;
`endif
      end
      default: stall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_lsu_controller.sv
// tb_lsu_controller: scoreboard bench for lsu_controller.
// Directed accesses push expected bus requests, stall lengths and loads to queues.
module tb_lsu_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        red_enable = 1'b0;
  logic        write_enable = 1'b0;
  logic [2:0]  memory_type = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid = 1'b0;
  logic [31:0] bus_rdata = 32'd0;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_fault;
`endif

  lsu_controller #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .red_enable(red_enable),
    .write_enable(write_enable),
    .memory_type(memory_type),
    .addr(addr),
    .store_data(store_data),
    .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_be(bus_be),
    .bus_wdata(bus_wdata),
    .bus_rsp_valid(bus_rsp_valid),
    .bus_rdata(bus_rdata),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign_fault(misalign_fault),
`endif
    .stall(stall),
    .load_valid(load_valid),
    .load_data(load_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [68:0] bus_q[$];
  logic [31:0] ld_q[$];
  int          stall_q[$];
  int          fault_q[$];
  logic [31:0] last_ld = 32'd0;

  logic [103:0] outs;
`ifdef LSU_MISALIGN_TRAP_EN
  logic         fault_bit;
  assign fault_bit = misalign_fault;
`else
  logic         fault_bit;
  assign fault_bit = 1'b0;
`endif
  assign outs = {bus_req_valid, bus_we, bus_addr, bus_be, bus_wdata,
                 stall, load_valid, load_data[31:1], load_data[0] | fault_bit};

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic extra(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: unexpected DUT output at %0t", nm, $time);
  endtask

  logic        prev_hold = 1'b0;
  logic [68:0] prev_bus = '0;
  int          run = 0;

  always @(negedge clk) begin
    logic [68:0] cur;
    cur = {bus_we, bus_addr, bus_be, bus_wdata};
    if (bus_req_valid && prev_hold) chk("req_hold", 128'(cur), 128'(prev_bus));
    prev_hold = bus_req_valid && !bus_req_ready;
    prev_bus  = cur;
    if (bus_req_valid && bus_req_ready) begin
      if (bus_q.size() > 0) chk("bus_req", 128'(cur), 128'(bus_q.pop_front()));
      else extra("bus_req");
    end
    if (load_valid) begin
      if (ld_q.size() > 0) chk("load_data", 128'(load_data), 128'(ld_q.pop_front()));
      else extra("load_valid");
    end
`ifdef LSU_MISALIGN_TRAP_EN
    if (misalign_fault) begin
      if (fault_q.size() > 0) begin
        void'(fault_q.pop_front());
        chk("fault_nold", 128'(load_valid), 128'(0));
      end else extra("misalign_fault");
    end
`endif
    if (stall) run++;
    else if (run > 0) begin
      if (stall_q.size() > 0) chk("stall_len", 128'(run), 128'(stall_q.pop_front()));
      else extra("stall");
      run = 0;
    end
  end

  task automatic access(input logic w, input logic r, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d,
                        input int rdly, input int rsp_dly,
                        input logic [31:0] rdata, input logic trap,
                        input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wd, input logic [31:0] e_ld);
    if (trap) begin
      fault_q.push_back(1);
      stall_q.push_back(1);
    end else begin
      bus_q.push_back({w, e_addr, e_be, e_wd});
      if (!w) ld_q.push_back(e_ld);
      stall_q.push_back(2 + rdly + (w ? 0 : rsp_dly));
    end
    @(posedge clk); #1;
    write_enable  = w;
    red_enable    = r;
    memory_type   = t;
    addr          = a;
    store_data    = d;
    bus_req_ready = (rdly == 0);
    @(posedge clk); #1;
    write_enable = 1'b0;
    red_enable   = 1'b0;
    if (trap) begin
      bus_req_ready = 1'b0;
      chk("trap_ld_keep", 128'(load_data), 128'(last_ld));
    end else begin
      repeat (rdly) begin
        @(posedge clk); #1;
      end
      bus_req_ready = 1'b1;
      @(posedge clk); #1;
      bus_req_ready = 1'b0;
      if (!w) begin
        repeat (rsp_dly - 1) begin
          @(posedge clk); #1;
        end
        bus_rsp_valid = 1'b1;
        bus_rdata     = rdata;
        @(posedge clk); #1;
        bus_rsp_valid = 1'b0;
        last_ld       = e_ld;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outs", 128'(outs), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // w r type addr data rdly rspdly rdata trap e_addr e_be e_wdata e_ld
    access(1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0,
           32'h100, 4'b1111, 32'hDEADBEEF, 0);
    access(1, 0, 3'b000, 32'h203, 32'h000000A5, 0, 0, 0, 0,
           32'h200, 4'b1000, 32'hA5A5A5A5, 0);
    access(0, 1, 3'b000, 32'h102, 0, 0, 3, 32'h0080FF00, 0,
           32'h100, 4'b0100, 0, 32'hFFFFFF80);
    access(0, 1, 3'b011, 32'h102, 0, 0, 1, 32'h0080FF00, 0,
           32'h100, 4'b0100, 0, 32'h00000080);
    access(0, 1, 3'b001, 32'h106, 0, 5, 1, 32'h80011234, 0,
           32'h104, 4'b1100, 0, 32'hFFFF8001);
    access(0, 1, 3'b100, 32'h104, 0, 1, 2, 32'h8001F00F, 0,
           32'h104, 4'b0011, 0, 32'h0000F00F);
    access(1, 0, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, 0, 0,
           32'h100, 4'b1100, 32'hABCDABCD, 0);
    access(1, 0, 3'b111, 32'h10C, 32'hCAFEF00D, 2, 0, 0, 0,
           32'h10C, 4'b1111, 32'hCAFEF00D, 0);
    access(0, 1, 3'b010, 32'h108, 0, 0, 1, 32'h12345678, 0,
           32'h108, 4'b1111, 0, 32'h12345678);
    access(1, 1, 3'b010, 32'h110, 32'h01020304, 0, 0, 0, 0,
           32'h110, 4'b1111, 32'h01020304, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    access(0, 1, 3'b010, 32'h101, 0, 0, 1, 32'h11223344, 1,
           0, 0, 0, 0);
`else
    access(0, 1, 3'b010, 32'h101, 0, 0, 1, 32'h11223344, 0,
           32'h100, 4'b1111, 0, 32'h11223344);
`endif

    // lh accepted, reset lands while waiting for the response
    bus_q.push_back({1'b0, 32'h200, 4'b0011, 32'h0});
    stall_q.push_back(3);
    @(posedge clk); #1;
    red_enable    = 1'b1;
    memory_type   = 3'b001;
    addr          = 32'h200;
    store_data    = 32'h0;
    bus_req_ready = 1'b1;
    @(posedge clk); #1;
    red_enable = 1'b0;
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_outs", 128'(outs), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus_rsp_valid = 1'b1;
    bus_rdata     = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0;
    chk("post_reset_outs", 128'(outs), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_idle", 128'(outs), 128'(0));

    chk("bus_q_left", 128'(bus_q.size()), 128'(0));
    chk("ld_q_left", 128'(ld_q.size()), 128'(0));
    chk("stall_q_left", 128'(stall_q.size()), 128'(0));
    chk("fault_q_left", 128'(fault_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
